// File: rtl/viterbi_pkg.sv
// Shared types and width helpers for the parametrised Viterbi traceback unit.
package viterbi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        EMIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } tbu_state_e;

    function automatic int unsigned ns(input int unsigned k);
        return 32'd1 << (k - 32'd1);
    endfunction

    function automatic int unsigned state_w(input int unsigned k);
        return k - 32'd1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned tb_len, input int unsigned dec_len);
        int unsigned m;
        m = (tb_len > dec_len) ? tb_len : dec_len;
        return $clog2(m + 32'd1);
    endfunction

endpackage

// File: rtl/viterbi_tbu_param_lifo.sv
// Bit-wide stack that reverses traceback order into forward time order.
module tbu_lifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic empty,
    output logic full
);
    localparam int unsigned PW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    assign empty = (ptr_q == '0);
    assign full  = (ptr_q == PW'(DEPTH));

    // dout is the top of stack, ptr_q points one past it
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        dout  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ptr_q == PW'(i + 1)) dout = mem_q[i];
        end
        if (clr) begin
            ptr_d = '0;
        end else if (push && !full) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ptr_q == PW'(i)) mem_d[i] = din;
            end
            ptr_d = ptr_q + PW'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
            ptr_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/viterbi_tbu_param.sv
// Parametrised Viterbi traceback unit: convergence walk, then decode with handshakes.
// Define VITERBI_TBU_LIFO_EN to reverse output into forward time order via a LIFO.
module viterbi_tbu_param
    import viterbi_pkg::*;
#(
    parameter int unsigned K       = 4,
    parameter int unsigned TB_LEN  = 16,
    parameter int unsigned DEC_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  start,
    input  logic [state_w(K)-1:0] start_state,
    input  logic                  dec_valid,
    input  logic [ns(K)-1:0]      dec_word,
    output logic                  dec_ready,
    output logic                  out_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);
    localparam int unsigned SW = state_w(K);
    localparam int unsigned CW = cnt_w(TB_LEN, DEC_LEN);
    localparam logic [CW-1:0] TB_LAST  = CW'((TB_LEN == 0) ? 0 : TB_LEN - 1);
    localparam logic [CW-1:0] DEC_LAST = CW'(DEC_LEN - 1);
`ifndef VITERBI_TBU_LIFO_EN
    localparam logic [CW-1:0] DEC_END  = CW'(DEC_LEN);
`endif

    tbu_state_e    fsm_q, fsm_d;
    logic [SW-1:0] st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          out_bit_q, out_bit_d;
    logic          out_last_q, out_last_d;
    logic          accept;
    logic [SW-1:0] st_step;

`ifdef VITERBI_TBU_LIFO_EN
    logic lifo_push, lifo_pop, lifo_clr, lifo_dout, lifo_empty, lifo_full;

    assign lifo_clr = !enable || (fsm_q == IDLE);

    tbu_lifo #(.DEPTH(DEC_LEN)) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (lifo_clr),
        .push  (lifo_push),
        .pop   (lifo_pop),
        .din   (st_q[0]),
        .dout  (lifo_dout),
        .empty (lifo_empty),
        .full  (lifo_full)
    );
`endif

    // One traceback step: predecessor = {decision, state >> 1}
    assign st_step   = {dec_word[st_q], st_q[SW-1:1]};
    assign accept    = dec_valid && dec_ready;
    assign busy      = (fsm_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fsm_q <= IDLE;
        else      fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        if (!enable) begin
            fsm_d = IDLE;
        end else begin
            case (fsm_q)
                IDLE: if (start) fsm_d = (TB_LEN == 0) ? EMIT : CONV;
                CONV: if (accept && cnt_q == TB_LAST) fsm_d = EMIT;
`ifdef VITERBI_TBU_LIFO_EN
                EMIT:  if (accept && cnt_q == DEC_LAST) fsm_d = DRAIN;
                DRAIN: if (out_valid_q && out_ready && out_last_q) fsm_d = DONE;
`else
                // counter parks at DEC_LEN until the last bit is taken
                EMIT: if (cnt_q == DEC_END && out_valid_q && out_ready) fsm_d = DONE;
`endif
                DONE:    fsm_d = IDLE;
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dec_ready   = 1'b0;
        st_d        = st_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_last_d  = out_last_q;
`ifdef VITERBI_TBU_LIFO_EN
        lifo_push   = 1'b0;
        lifo_pop    = 1'b0;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        case (fsm_q)
            IDLE: begin
                if (start && enable) begin
                    st_d  = start_state;
                    cnt_d = '0;
                end
            end
            CONV: begin
                dec_ready = 1'b1;
                if (dec_valid) begin
                    st_d  = st_step;
                    cnt_d = (cnt_q == TB_LAST) ? '0 : cnt_q + CW'(1);
                end
            end
`ifdef VITERBI_TBU_LIFO_EN
            EMIT: begin
                dec_ready = 1'b1;
                if (dec_valid) begin
                    st_d      = st_step;
                    lifo_push = !lifo_full;
                    cnt_d     = (cnt_q == DEC_LAST) ? '0 : cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if ((!out_valid_q || out_ready) && !lifo_empty) begin
                    lifo_pop    = 1'b1;
                    out_valid_d = 1'b1;
                    out_bit_d   = lifo_dout;
                    out_last_d  = (cnt_q == DEC_LAST);
                    cnt_d       = cnt_q + CW'(1);
                end
            end
`else
            EMIT: begin
                dec_ready = (cnt_q != DEC_END) && (!out_valid_q || out_ready);
                if (dec_valid && dec_ready) begin
                    st_d        = st_step;
                    cnt_d       = cnt_q + CW'(1);
                    out_valid_d = 1'b1;
                    out_bit_d   = st_q[0];
                    out_last_d  = (cnt_q == DEC_LAST);
                end
            end
`endif
            default: ;
        endcase
        // enable low discards any partial block
        if (!enable) begin
            dec_ready   = 1'b0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
`ifdef VITERBI_TBU_LIFO_EN
            lifo_push   = 1'b0;
            lifo_pop    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_viterbi_tbu_param.sv
// Directed bench for viterbi_tbu_param (K=4, TB_LEN=4, DEC_LEN=4) with an output scoreboard.
module tb_viterbi_tbu_param;
    localparam int unsigned K   = 4;
    localparam int unsigned TB  = 4;
    localparam int unsigned DEC = 4;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, enable, start, dec_valid, out_ready;
    logic [2:0] start_state;
    logic [7:0] dec_word;
    logic       dec_ready, out_bit, out_valid, out_last, busy;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    viterbi_tbu_param #(.K(K), .TB_LEN(TB), .DEC_LEN(DEC)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start       (start),
        .start_state (start_state),
        .dec_valid   (dec_valid),
        .dec_word    (dec_word),
        .dec_ready   (dec_ready),
        .out_bit     (out_bit),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output handshake is checked against the head of exp_q
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_bit", 32'(out_bit), 32'(e.b));
                check("out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference traceback: emitted bits in traceback order, bits[0] first
    task automatic model_bits(input logic [2:0] s0, input logic [7:0] w [8], output logic [3:0] bits);
        logic [2:0] s;
        s = s0;
        bits = '0;
        for (int i = 0; i < 8; i++) begin
            if (i >= int'(TB)) bits = {s[0], bits[3:1]};
            s = {w[i][s], s[2:1]};
        end
    endtask

    task automatic push_expected(input logic [3:0] bits);
        for (int j = 0; j < 4; j++) begin
            exp_t e;
`ifdef VITERBI_TBU_LIFO_EN
            e.b = bits[3 - j];
`else
            e.b = bits[j];
`endif
            e.last = (j == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [2:0] s);
        start = 1'b1;
        start_state = s;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        dec_valid = 1'b1;
        dec_word = w;
        do begin
            @(negedge clk);
            acc = dec_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 32'(dec_ready), 32'd1);
        dec_valid = 1'b0;
    endtask

    task automatic run_block(input logic [2:0] s0, input logic [7:0] w [8], input bit restart_mid);
        logic [3:0] bits;
        model_bits(s0, w, bits);
        push_expected(bits);
        do_start(s0);
        for (int i = 0; i < 8; i++) begin
            if (restart_mid && i == 2) do_start(~s0);
            send_word(w[i]);
            if (i == int'(TB) - 1) check("conv_quiet", 32'(out_valid), 32'd0);
        end
`ifndef VITERBI_TBU_LIFO_EN
        @(posedge clk); #1;
        check("busy_done", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("busy_idle", 32'(busy), 32'd0);
`else
        for (int n = 0; n < 100 && busy; n++) begin
            @(posedge clk); #1;
        end
        check("busy_idle", 32'(busy), 32'd0);
`endif
        check("exp_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] w [8];
        logic [3:0] bits;

        rst = 1'b0; enable = 1'b1; start = 1'b0; start_state = '0;
        dec_valid = 1'b0; dec_word = '0; out_ready = 1'b1;
        #2;
        check("rst_dec_ready", 32'(dec_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bit", 32'(out_bit), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // dec_valid in IDLE is not accepted
        dec_valid = 1'b1; dec_word = 8'hFF;
        @(negedge clk);
        check("idle_dec_ready", 32'(dec_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        dec_valid = 1'b0;

        // Basic decode
        w = '{default: 8'hFF};
        run_block(3'b101, w, 1'b0);

        // Convergence from 111, with an ignored start while busy
        w = '{default: 8'h00};
        run_block(3'b111, w, 1'b1);

        // Path toward the LIFO pattern: traceback bits 1,0,0,1
        w = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
        run_block(3'b010, w, 1'b0);

`ifndef VITERBI_TBU_LIFO_EN
        // Backpressure on the first EMIT bit
        for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
        model_bits(3'b011, w, bits);
        push_expected(bits);
        out_ready = 1'b0;
        do_start(3'b011);
        for (int i = 0; i < 5; i++) send_word(w[i]);
        dec_valid = 1'b1; dec_word = w[5];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_dec_ready", 32'(dec_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_bit", 32'(out_bit), 32'(bits[0]));
            check("bp_out_last", 32'(out_last), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 5; i < 8; i++) send_word(w[i]);
        for (int n = 0; n < 100 && busy; n++) begin
            @(posedge clk); #1;
        end
        check("bp_busy_idle", 32'(busy), 32'd0);
        check("bp_exp_left", 32'(exp_q.size()), 32'd0);
`endif

        // Abort after two EMIT accepts
        for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
        model_bits(3'b110, w, bits);
`ifndef VITERBI_TBU_LIFO_EN
        exp_q.push_back('{b: bits[0], last: 1'b0});
        exp_q.push_back('{b: bits[1], last: 1'b0});
`endif
        do_start(3'b110);
        for (int i = 0; i < 6; i++) send_word(w[i]);
        enable = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_last", 32'(out_last), 32'd0);
        check("abort_exp_left", 32'(exp_q.size()), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
        run_block(3'b001, w, 1'b0);

        // Asynchronous reset mid-CONV
        do_start(3'b100);
        send_word(8'h5A);
        send_word(8'hA5);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_dec_ready", 32'(dec_ready), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_bit", 32'(out_bit), 32'd0);
        check("arst_out_last", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        do_start(3'b111);
        check("arst_start_ignored", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("arst_post_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
        run_block(3'b100, w, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
